dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arbiter_if.sv | 29 ++
 rtl/rr_pick2.sv | 19 +
 rtl/dm_arbiter.sv | 121 ++++++++++++
 tb/tb_dm_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the per-beat address step.
package dm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int PORT_CPU   = 0;
  localparam int PORT_DMA   = 1;
  localparam int WORD_BYTES = 4;

  // Port index to one-hot grant vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bus of the data-memory arbiter; master = requesters,
// slave = arbiter.
interface dm_arbiter_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       req;
  logic [1:0]       we;
  logic [31:0]      addr0;
  logic [31:0]      addr1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [31:0]      wdata0;
  logic [31:0]      wdata1;
  logic [1:0]       gnt;
  logic [1:0]       beat_ack;
  logic [1:0]       done;
  logic [31:0]      rdata;
  logic [1:0]       rvalid;

  modport master (
    output req, we, addr0, addr1, len0, len1, wdata0, wdata1,
    input  gnt, beat_ack, done, rdata, rvalid
  );

  modport slave (
    input  req, we, addr0, addr1, len0, len1, wdata0, wdata1,
    output gnt, beat_ack, done, rdata, rvalid
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that was not
// granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port burst arbiter in front of a single-ported data memory: CPU MEM
// stage on port 0, DMA/bridge on port 1, one beat per cycle while granted.
module dm_arbiter #(
  parameter int LEN_W      = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   bus,
  output logic [31:0]   dm_a,
  output logic [31:0]   dm_wd,
  output logic          dm_wr,
  input  logic [31:0]   dm_rd
);
  import dm_arb_pkg::*;

  state_t           state_reg, state_next;
  logic             port_reg, port_next;
  logic             last_reg, last_next;
  logic             we_reg, we_next;
  logic [31:0]      base_reg, base_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      rdata_reg;
  logic [1:0]       rvalid_reg;

  logic [1:0] pick;
  logic       busy;
  logic       last_beat;
  logic [1:0] port_oh;

  rr_pick2 u_pick (
    .req  (bus.req),
    .last (last_reg),
    .pick (pick)
  );

  assign busy      = (state_reg == BUSY);
  assign last_beat = busy && (cnt_reg == len_reg);
  assign port_oh   = port_onehot(port_reg);

  always_comb begin
    state_next = state_reg;
    port_next  = port_reg;
    last_next  = last_reg;
    we_next    = we_reg;
    base_next  = base_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|pick) begin
          state_next = BUSY;
          port_next  = pick[1];
          last_next  = pick[1];
          cnt_next   = '0;
          if (pick[1]) begin
            we_next   = bus.we[1];
            base_next = {bus.addr1[31:2], 2'b00};
            len_next  = bus.len1;
          end else begin
            we_next   = bus.we[0];
            base_next = {bus.addr0[31:2], 2'b00};
            len_next  = bus.len0;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst parameters are frozen at grant, so requester changes mid-burst are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      port_reg  <= 1'b0;
      last_reg  <= 1'(PORT_DMA);
      we_reg    <= 1'b0;
      base_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      port_reg  <= port_next;
      last_reg  <= last_next;
      we_reg    <= we_next;
      base_reg  <= base_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg  <= '0;
      rvalid_reg <= '0;
    end else begin
      rvalid_reg <= (busy && !we_reg) ? port_oh : 2'b00;
      if (busy && !we_reg) begin
        rdata_reg <= dm_rd;
      end
    end
  end

  // Beat-side outputs decode straight from state so reset silences them at once.
  assign dm_a         = busy ? (base_reg + 32'(WORD_BYTES) * 32'(cnt_reg)) : 32'h0;
  assign dm_wr        = busy && we_reg;
  assign dm_wd        = port_reg ? bus.wdata1 : bus.wdata0;
  assign bus.gnt      = busy ? port_oh : 2'b00;
  assign bus.beat_ack = busy ? port_oh : 2'b00;
  assign bus.done     = last_beat ? port_oh : 2'b00;
  assign bus.rdata    = rdata_reg;
  assign bus.rvalid   = rvalid_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: expected beats are queued by the stimulus,
// a negedge monitor pops and compares each presented beat and read return.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if #(.LEN_W(4)) bus ();

  logic [31:0] dm_a, dm_wd, dm_rd;
  logic        dm_wr;

  dm_arbiter #(.LEN_W(4), .WORD_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dm_a  (dm_a),
    .dm_wd (dm_wd),
    .dm_wr (dm_wr),
    .dm_rd (dm_rd)
  );

  function automatic logic [31:0] dm_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign dm_rd = dm_model(dm_a);

  function automatic logic [31:0] oh(input int p);
    return (p == 1) ? 32'd2 : 32'd1;
  endfunction

  typedef struct {
    int          port;
    logic [31:0] a;
    bit          wr;
    logic [31:0] wd;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_beat(input int p, input logic [31:0] a, input bit wr,
                           input logic [31:0] wd, input bit last);
    beat_t b;
    b.port = p; b.a = a; b.wr = wr; b.wd = wd; b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: compares every issued beat and every read return.
  beat_t       mon_e;
  bit          rd_pend = 0;
  int          rd_port = 0;
  logic [31:0] rd_data = '0;
  bit          prev_done = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        check("rvalid", 32'(bus.rvalid), oh(rd_port));
        check("rdata", bus.rdata, rd_data);
        $display("read return port%0d rdata=0x%08h", rd_port, bus.rdata);
        rd_pend = 0;
      end else if (bus.rvalid !== 2'b00) begin
        check("rvalid_spurious", 32'(bus.rvalid), 32'd0);
      end
      if (bus.beat_ack !== 2'b00) begin
        if (prev_done) check("idle_gap", 32'(bus.beat_ack), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bus.beat_ack), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_ack", 32'(bus.beat_ack), oh(mon_e.port));
          check("gnt", 32'(bus.gnt), oh(mon_e.port));
          check("dm_a", dm_a, mon_e.a);
          check("dm_wr", 32'(dm_wr), 32'(mon_e.wr));
          if (mon_e.wr) check("dm_wd", dm_wd, mon_e.wd);
          check("done", 32'(bus.done), mon_e.last ? oh(mon_e.port) : 32'd0);
          $display("beat port%0d dm_a=0x%08h wr=%0d done=%b", mon_e.port, dm_a, dm_wr, bus.done);
          if (!mon_e.wr) begin
            rd_pend = 1;
            rd_port = mon_e.port;
            rd_data = dm_model(mon_e.a);
          end
        end
      end
      prev_done = (bus.done !== 2'b00);
    end
  end

  task automatic burst(input int p, input bit w, input logic [31:0] a, input logic [3:0] l,
                       input logic [31:0] wd0, input bit drop);
    int beats = 0;
    bit fin = 0;
    if (p == 0) begin bus.addr0 = a; bus.len0 = l; bus.wdata0 = wd0; end
    else        begin bus.addr1 = a; bus.len1 = l; bus.wdata1 = wd0; end
    bus.we[p]  = w;
    bus.req[p] = 1'b1;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      @(negedge clk);
      if (bus.beat_ack[p]) begin
        beats++;
        fin = bus.done[p];
        @(posedge clk);
        #1;
        if (p == 0) bus.wdata0 = wd0 + 32'(beats);
        else        bus.wdata1 = wd0 + 32'(beats);
        if (fin) bus.req[p] = 1'b0;
        if (drop && beats == 2) begin
          bus.req[p] = 1'b0;
          if (p == 0) bus.len0 = '0; else bus.len1 = '0;
        end
      end
    end
    check($sformatf("burst_done_p%0d", p), 32'(fin), 32'd1);
    bus.req[p] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    bus.req = '0; bus.we = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    check("rst_dm_a", dm_a, 32'd0);
    check("rst_beat_ack", 32'(bus.beat_ack), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Single CPU write, unaligned base.
    push_beat(0, 32'h0000_1004, 1, 32'hDEAD_BEEF, 1);
    burst(0, 1, 32'h0000_1006, 4'd0, 32'hDEAD_BEEF, 0);
    drain();

    // DMA 4-beat read.
    push_beat(1, 32'h0000_0100, 0, 32'h0, 0);
    push_beat(1, 32'h0000_0104, 0, 32'h0, 0);
    push_beat(1, 32'h0000_0108, 0, 32'h0, 0);
    push_beat(1, 32'h0000_010C, 0, 32'h0, 1);
    burst(1, 0, 32'h0000_0100, 4'd3, 32'h0, 0);
    drain();

    // Address wrap at top of memory.
    push_beat(1, 32'hFFFF_FFFC, 1, 32'h1111_0000, 0);
    push_beat(1, 32'h0000_0000, 1, 32'h1111_0001, 1);
    burst(1, 1, 32'hFFFF_FFFC, 4'd1, 32'h1111_0000, 0);
    drain();

    // Tie with port1 granted last: port0 first, port1 after one idle cycle.
    push_beat(0, 32'h0000_0300, 1, 32'h0000_00A0, 0);
    push_beat(0, 32'h0000_0304, 1, 32'h0000_00A1, 1);
    push_beat(1, 32'h0000_0400, 0, 32'h0, 1);
    fork
      burst(0, 1, 32'h0000_0300, 4'd1, 32'h0000_00A0, 0);
      burst(1, 0, 32'h0000_0400, 4'd0, 32'h0, 0);
    join
    drain();

    // Port0 alone, then a tie goes to port1.
    push_beat(0, 32'h0000_0500, 0, 32'h0, 1);
    burst(0, 0, 32'h0000_0500, 4'd0, 32'h0, 0);
    drain();
    push_beat(1, 32'h0000_0600, 1, 32'h0000_00B0, 1);
    push_beat(0, 32'h0000_0510, 0, 32'h0, 1);
    fork
      burst(1, 1, 32'h0000_0600, 4'd0, 32'h0000_00B0, 0);
      burst(0, 0, 32'h0000_0510, 4'd0, 32'h0, 0);
    join
    drain();

    // req and len dropped after beat 2 of a 6-beat write.
    push_beat(0, 32'h0000_0700, 1, 32'h0000_00C0, 0);
    push_beat(0, 32'h0000_0704, 1, 32'h0000_00C1, 0);
    push_beat(0, 32'h0000_0708, 1, 32'h0000_00C2, 0);
    push_beat(0, 32'h0000_070C, 1, 32'h0000_00C3, 0);
    push_beat(0, 32'h0000_0710, 1, 32'h0000_00C4, 0);
    push_beat(0, 32'h0000_0714, 1, 32'h0000_00C5, 1);
    burst(0, 1, 32'h0000_0700, 4'd5, 32'h0000_00C0, 1);
    drain();

    // Reset asserted during beat 2 of a 4-beat write.
    push_beat(0, 32'h0000_0200, 1, 32'h0000_00E0, 0);
    bus.addr0 = 32'h0000_0200; bus.len0 = 4'd3; bus.wdata0 = 32'h0000_00E0;
    bus.we[0] = 1'b1; bus.req[0] = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 16 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.beat_ack[0];
    end
    check("rst_test_first_beat", 32'(seen), 32'd1);
    @(posedge clk);
    #1 bus.wdata0 = 32'h0000_00E1;
    #2 reset = 1'b0;
    #1;
    check("midrst_dm_wr", 32'(dm_wr), 32'd0);
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_beat_ack", 32'(bus.beat_ack), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_dm_a", dm_a, 32'd0);
    bus.req[0] = 1'b0;
    bus.we[0] = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_resume", 32'(exp_q.size()), 32'd0);

    // Tie right after reset: port0 wins.
    push_beat(0, 32'h0000_0800, 0, 32'h0, 1);
    push_beat(1, 32'h0000_0900, 0, 32'h0, 1);
    fork
      burst(0, 0, 32'h0000_0800, 4'd0, 32'h0, 0);
      burst(1, 0, 32'h0000_0900, 4'd0, 32'h0, 0);
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
